// File: rtl/conv_window_gen.sv
// conv_window_gen
//   Turns a raster-order 8-bit signed pixel stream into 5x5 sliding windows
//   (valid-mode, stride 1, no padding) for the downstream 5x5 convolution.
//   Four line buffers of IMG_W entries hold the previous four lines; a 5x5
//   register array holds the current neighbourhood.
//   Optional feature: define WINGEN_LAST_EN to add the win_last output, which
//   flags the final window of each frame.
module conv_window_gen #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pix_valid,
    input  logic signed [7:0]             pix_in,
    input  logic                          sof,
    output logic signed [4:0][4:0][7:0]   window,
    output logic                          win_valid,
`ifdef WINGEN_LAST_EN
    output logic                          win_last,
`endif
    output logic [$clog2(IMG_H)-1:0]      win_row,
    output logic [$clog2(IMG_W)-1:0]      win_col
);

    localparam int DATA_W = 8;
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int COL_W  = $clog2(IMG_W);

    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(4);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(4);

    // lb[0] holds line row-4, lb[3] holds line row-1; never reset, stale
    // contents are masked by the row counter.
    logic signed [DATA_W-1:0] lb [4][IMG_W];

    logic [ROW_W-1:0] row_cnt;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;
    logic             emit;

    // Position of the pixel being accepted; sof forces it to the frame origin.
    always_comb begin
        cur_row = row_cnt;
        cur_col = col_cnt;
        if (sof) begin
            cur_row = '0;
            cur_col = '0;
        end
        emit = pix_valid && (cur_row >= ROW_FIRST) && (cur_col >= COL_FIRST);
    end

    // Raster counters: advance per accepted pixel, wrap at line and frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (pix_valid) begin
            if (cur_col == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_cnt <= cur_col + 1'b1;
                row_cnt <= cur_row;
            end
        end
    end

    // Line buffers: the column at cur_col moves up one line, new pixel enters at the bottom.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            for (int i = 0; i < 3; i++) begin
                lb[i][cur_col] <= lb[i+1][cur_col];
            end
            lb[3][cur_col] <= pix_in;
        end
    end

    // Window: shift left one column and load the new rightmost column.
    always_ff @(posedge clk) begin
        if (rst) begin
            window <= '0;
        end else if (pix_valid) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 4; j++) begin
                    window[i][j] <= window[i][j+1];
                end
            end
            for (int i = 0; i < 4; i++) begin
                window[i][4] <= lb[i][cur_col];
            end
            window[4][4] <= pix_in;
        end
    end

    // Window qualifier and top-left coordinates, aligned with the window register.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            win_valid <= emit;
            if (emit) begin
                win_row <= cur_row - ROW_FIRST;
                win_col <= cur_col - COL_FIRST;
            end
        end
    end

`ifdef WINGEN_LAST_EN
    // Final window of the frame is the one produced by the last pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_last <= 1'b0;
        end else begin
            win_last <= emit && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end
    end
`endif

endmodule
